// File: rtl/mem_access_unit.sv
// Data-memory initiator: checks alignment and range, then issues a req/gnt memory access.
// It returns extended load data or an address exception. Define MEM_TRACE_EN to print granted stores.
module mem_access_unit #(
    parameter int ADDR_W      = 14,
    parameter int DEPTH_WORDS = 3072
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [2:0]        cpu_op,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [31:0]       cpu_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_exc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t     state;
    logic [2:0] op_q;
    logic [1:0] lo_q;

    logic        is_store, misaligned, bad;
    logic [3:0]  be;
    logic [31:0] wd;

    assign is_store = cpu_op >= 3'd5;

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0001 << cpu_addr[1:0];
        wd         = {4{cpu_wdata[7:0]}};
        case (cpu_op)
            3'd0, 3'd5: begin
                misaligned = cpu_addr[1:0] != 2'b00;
                be         = 4'b1111;
                wd         = cpu_wdata;
            end
            3'd1, 3'd2, 3'd6: begin
                misaligned = cpu_addr[0];
                be         = cpu_addr[1] ? 4'b1100 : 4'b0011;
                wd         = {2{cpu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign bad = misaligned || (cpu_addr >= LIMIT);

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        h = lo[1] ? w[31:16] : w[15:0];
        b = 8'(w >> {lo, 3'b000});
        case (op)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            default: return w;
        endcase
    endfunction

`ifdef MEM_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] trace_data;
    always_comb begin
        trace_data = {24'h0, mem_wdata[7:0]};
        if (op_q == 3'd5) trace_data = mem_wdata;
        else if (op_q == 3'd6) trace_data = {16'h0, mem_wdata[15:0]};
    end
`else
    logic pc_unused;
    assign pc_unused = ^cpu_pc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cpu_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_exc   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            op_q       <= '0;
            lo_q       <= '0;
`ifdef MEM_TRACE_EN
            pc_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (cpu_valid) begin
                    op_q      <= cpu_op;
                    lo_q      <= cpu_addr[1:0];
                    cpu_ready <= 1'b0;
`ifdef MEM_TRACE_EN
                    pc_q      <= cpu_pc;
`endif
                    if (bad) begin
                        // excepting accesses never reach the memory
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_exc   <= is_store ? 2'd2 : 2'd1;
                    end else begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= cpu_addr[ADDR_W-1:2];
                        mem_be    <= be;
                        mem_wdata <= wd;
                    end
                end
                REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    if (mem_we) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_exc   <= 2'd0;
`ifdef MEM_TRACE_EN
                        $display("@%h: *%h <= %h", pc_q,
                                 {{(34-ADDR_W){1'b0}}, mem_addr, lo_q}, trace_data);
`endif
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (mem_rvalid) begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= extract(op_q, lo_q, mem_rdata);
                    resp_exc   <= 2'd0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_exc   <= '0;
                    cpu_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a driver pushes expected responses into a queue and a monitor checks them.
`timescale 1ns/1ps
module tb_mem_access_unit;
    logic        clk = 0, rst = 1;
    logic        cpu_valid = 0, cpu_ready;
    logic [2:0]  cpu_op = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_pc = 0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 32'h5A5A5A5A;

    mem_access_unit #(.ADDR_W(14), .DEPTH_WORDS(3072)) dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  exc;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // monitor: every response pulse must match the oldest expectation, at the expected cycle
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_exc", 32'(resp_exc), 32'(e.exc));
                chk("resp_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int gd, input int rvd,
                       input logic [1:0] eexc, input logic [31:0] erd,
                       input logic [11:0] ema, input logic [3:0] ebe, input logic [31:0] ewd);
        bit st;
        int n;
        exp_t e;
        st = (op >= 3'd5);
        @(negedge clk);
        chk("ready_before", 32'(cpu_ready), 32'd1);
        cpu_valid = 1; cpu_op = op; cpu_addr = addr; cpu_wdata = wd; cpu_pc = 32'h400 + addr;
        @(posedge clk); #1;
        cpu_valid = 0;
        e.rd = erd; e.exc = eexc;
        e.at = cyc + ((eexc != 0) ? 0 : (st ? 1 + gd : 2 + gd + rvd));
        exp_q.push_back(e);
        chk("ready_busy", 32'(cpu_ready), 32'd0);
        if (eexc != 0) begin
            chk("no_req_exc", 32'(mem_req), 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_addr", 32'(mem_addr), 32'(ema));
                chk("mem_be", 32'(mem_be), 32'(ebe));
                chk("mem_we", 32'(mem_we), 32'(st));
                if (st) chk("mem_wdata", mem_wdata, ewd);
                if (i == gd) mem_gnt = 1;
                @(posedge clk); #1;
                mem_gnt = 0;
            end
            chk("req_drop", 32'(mem_req), 32'd0);
            if (!st) begin
                for (int i = 0; i <= rvd; i++) begin
                    chk("ready_wait", 32'(cpu_ready), 32'd0);
                    if (i == rvd) begin mem_rvalid = 1; mem_rdata = rd; end
                    @(posedge clk); #1;
                    mem_rvalid = 0; mem_rdata = 32'h5A5A5A5A;
                end
            end
        end
        n = 0;
        while (!cpu_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_return", 32'(cpu_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        @(negedge clk); rst = 0;

        //   op  addr          wdata         rdata         gd rvd exc rdata_exp     maddr   be      wdata_exp
        run(5, 32'h10,   32'h12345678, 32'h0,        0, 0, 0, 32'h0,        12'h004, 4'hF, 32'h12345678);
        run(7, 32'h13,   32'h000000AB, 32'h0,        0, 0, 0, 32'h0,        12'h004, 4'h8, 32'hABABABAB);
        run(3, 32'h13,   32'h0,        32'hAB000000, 0, 0, 0, 32'hFFFFFFAB, 12'h004, 4'h8, 32'h0);
        run(4, 32'h13,   32'h0,        32'hAB000000, 0, 0, 0, 32'h000000AB, 12'h004, 4'h8, 32'h0);
        run(1, 32'h2,    32'h0,        32'h80010000, 0, 0, 0, 32'hFFFF8001, 12'h000, 4'hC, 32'h0);
        run(2, 32'h2,    32'h0,        32'h80010000, 0, 0, 0, 32'h00008001, 12'h000, 4'hC, 32'h0);
        run(1, 32'h3,    32'h0,        32'h0,        0, 0, 1, 32'h0,        12'h000, 4'h0, 32'h0);
        run(5, 32'h3000, 32'h11111111, 32'h0,        0, 0, 2, 32'h0,        12'h000, 4'h0, 32'h0);
        run(7, 32'h2FFF, 32'h0000005A, 32'h0,        0, 0, 0, 32'h0,        12'hBFF, 4'h8, 32'h5A5A5A5A);
        run(3, 32'h3000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        12'h000, 4'h0, 32'h0);
        run(3, 32'h2FFF, 32'h0,        32'h7F000000, 0, 0, 0, 32'h0000007F, 12'hBFF, 4'h8, 32'h0);
        run(0, 32'h20,   32'h0,        32'hDEADBEEF, 3, 1, 0, 32'hDEADBEEF, 12'h008, 4'hF, 32'h0);
        run(6, 32'h6,    32'h1234ABCD, 32'h0,        2, 0, 0, 32'h0,        12'h001, 4'hC, 32'hABCDABCD);
        run(3, 32'h1,    32'h0,        32'h00008000, 0, 0, 0, 32'hFFFFFF80, 12'h000, 4'h2, 32'h0);
        run(5, 32'h2,    32'h0,        32'h0,        0, 0, 2, 32'h0,        12'h000, 4'h0, 32'h0);
        run(2, 32'h1,    32'h0,        32'h0,        0, 0, 1, 32'h0,        12'h000, 4'h0, 32'h0);

        // reset while waiting for read data: access dropped, late rvalid ignored
        @(negedge clk);
        cpu_valid = 1; cpu_op = 0; cpu_addr = 32'h40; cpu_wdata = 0;
        @(posedge clk); #1; cpu_valid = 0; mem_gnt = 1;
        @(posedge clk); #1; mem_gnt = 0;
        chk("wait_ready", 32'(cpu_ready), 32'd0);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        chk("rstw_ready", 32'(cpu_ready), 32'd1);
        chk("rstw_req", 32'(mem_req), 32'd0);
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1; mem_rvalid = 0;
        chk("late_rvalid_resp", 32'(resp_valid), 32'd0);
        chk("late_rvalid_ready", 32'(cpu_ready), 32'd1);

        // reset while requesting: mem_req drops next cycle, stray gnt in IDLE ignored
        @(negedge clk);
        cpu_valid = 1; cpu_op = 5; cpu_addr = 32'h44; cpu_wdata = 32'h1;
        @(posedge clk); #1; cpu_valid = 0;
        chk("rstr_req_before", 32'(mem_req), 32'd1);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        chk("rstr_req_after", 32'(mem_req), 32'd0);
        mem_gnt = 1;
        @(posedge clk); #1; mem_gnt = 0;
        chk("idle_gnt_req", 32'(mem_req), 32'd0);
        chk("idle_gnt_resp", 32'(resp_valid), 32'd0);

        run(5, 32'h8, 32'hA5A5A5A5, 32'h0, 1, 0, 0, 32'h0, 12'h002, 4'hF, 32'hA5A5A5A5);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
